// File: rtl/pls_cnt_mod.sv
// Modulo-MOD up/down pulse counter for one digit of the watch time chain.
// Synchronises plsi/clr, counts the selected plsi edge, loads, and strobes co on wrap/borrow.
module pls_cnt_mod #(
    parameter int MOD  = 60,
    parameter int W    = 6,
    parameter int HALF = MOD / 2,
    parameter bit EDGE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         plsi,
    input  logic         en,
    input  logic         dn,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] qout,
    output logic         plso,
    output logic         co
);

    localparam logic [W-1:0] ZERO_C = {W{1'b0}};
    localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX_C  = W'(MOD - 1);
    // One extra bit so MOD == 2**W and HALF == MOD still compare correctly.
    localparam logic [W:0]   MOD_X  = (W+1)'(MOD);
    localparam logic [W:0]   HALF_X = (W+1)'(HALF);

    logic         clr_s0_q, clr_s1_q;
    logic         pl_s0_q, pl_s1_q;
    logic [W-1:0] qout_q, qout_d;
    logic         plso_q, plso_d;
    logic         co_q, co_d;
    logic         clr_ev_s;
    logic         pl_ev_s;

    function automatic logic [W-1:0] sat_load(input logic [W-1:0] v);
        if ({1'b0, v} >= MOD_X) begin
            return MAX_C;
        end else begin
            return v;
        end
    endfunction

    function automatic logic at_half(input logic [W-1:0] v);
        return ({1'b0, v} >= HALF_X);
    endfunction

    // Two-flop synchronisers for the asynchronous clear and count pulse inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_s0_q <= 1'b0;
            clr_s1_q <= 1'b0;
            pl_s0_q  <= 1'b0;
            pl_s1_q  <= 1'b0;
        end else begin
            clr_s0_q <= clr;
            clr_s1_q <= clr_s0_q;
            pl_s0_q  <= plsi;
            pl_s1_q  <= pl_s0_q;
        end
    end

    assign clr_ev_s = clr_s0_q & ~clr_s1_q;
    assign pl_ev_s  = EDGE ? (pl_s0_q & ~pl_s1_q) : (pl_s1_q & ~pl_s0_q);

    // Next-state: clear beats load, load beats an enabled pulse.
    always_comb begin
        qout_d = qout_q;
        plso_d = plso_q;
        co_d   = 1'b0;
        if (clr_ev_s) begin
            qout_d = ZERO_C;
            plso_d = 1'b0;
        end else if (ld) begin
            qout_d = sat_load(ld_val);
            plso_d = at_half(qout_d);
        end else if (pl_ev_s && en) begin
            if (!dn) begin
                if (qout_q >= MAX_C) begin
                    qout_d = ZERO_C;
                    co_d   = 1'b1;
                end else begin
                    qout_d = qout_q + ONE_C;
                end
            end else begin
                if (qout_q == ZERO_C) begin
                    qout_d = MAX_C;
                    co_d   = 1'b1;
                end else begin
                    qout_d = qout_q - ONE_C;
                end
            end
            plso_d = at_half(qout_d);
        end else begin
            qout_d = qout_q;
            plso_d = plso_q;
        end
    end

    // Counter state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qout_q <= ZERO_C;
            plso_q <= 1'b0;
            co_q   <= 1'b0;
        end else begin
            qout_q <= qout_d;
            plso_q <= plso_d;
            co_q   <= co_d;
        end
    end

    assign qout = qout_q;
    assign plso = plso_q;
    assign co   = co_q;

endmodule
